// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: steps instructions through fetch/decode/execute/memory/writeback
// with a memory-ready handshake, optional bne/addi decode and illegal-opcode/funct flagging.
module mips_multicycle_ctrl #(
  parameter bit SUPPORT_BNE   = 1'b1,
  parameter bit SUPPORT_ADDI  = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       pc_en,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  state_t state_reg, state_next;
  logic   bne_reg, bne_next;
  logic   bad_funct_reg, bad_funct_next;
  logic   ready;
  logic   is_bne_op, is_addi_op;
  logic [2:0] funct_alu;
  logic   funct_ok;

  assign ready      = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign is_bne_op  = SUPPORT_BNE && (opcode == OP_BNE);
  assign is_addi_op = SUPPORT_ADDI && (opcode == OP_ADDI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      bne_reg       <= 1'b0;
      bad_funct_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bne_reg       <= bne_next;
      bad_funct_reg <= bad_funct_next;
    end
  end

  always_comb begin
    funct_alu = 3'b010;
    funct_ok  = 1'b0;
    case (funct)
      6'b100000: begin funct_alu = 3'b010; funct_ok = 1'b1; end
      6'b100010: begin funct_alu = 3'b110; funct_ok = 1'b1; end
      6'b100100: begin funct_alu = 3'b000; funct_ok = 1'b1; end
      6'b100101: begin funct_alu = 3'b001; funct_ok = 1'b1; end
      6'b101010: begin funct_alu = 3'b111; funct_ok = 1'b1; end
      default:   ;
    endcase
  end

  // Defaults double as the reset output values: enables low, muxes 0, ALU add.
  always_comb begin
    alu_control    = 3'b010;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    pc_src         = 2'b00;
    iord           = 1'b0;
    mem_write      = 1'b0;
    ir_write       = 1'b0;
    reg_dest       = 1'b0;
    mem_to_reg     = 1'b0;
    reg_write      = 1'b0;
    pc_en          = 1'b0;
    illegal_op     = 1'b0;
    state_next     = state_reg;
    bne_next       = bne_reg;
    bad_funct_next = bad_funct_reg;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          alu_src_b = 2'b01;
          if (ready) begin
            ir_write   = 1'b1;
            pc_en      = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          bne_next  = is_bne_op;
          if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEMADR;
          else if (opcode == OP_RTYPE)            state_next = S_EXECUTE;
          else if (opcode == OP_BEQ || is_bne_op) state_next = S_BRANCH;
          else if (is_addi_op)                    state_next = S_ADDIEX;
          else if (opcode == OP_J)                state_next = S_JUMP;
          else begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          iord = 1'b1;
          if (ready) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
          if (ready) state_next = S_FETCH;
        end
        S_EXECUTE: begin
          alu_src_a      = 1'b1;
          alu_control    = funct_alu;
          bad_funct_next = !funct_ok;
          state_next     = S_ALUWB;
        end
        // An unknown funct is reported here, one cycle late, instead of writing back.
        S_ALUWB: begin
          reg_dest   = 1'b1;
          reg_write  = !bad_funct_reg;
          illegal_op = bad_funct_reg;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = 3'b110;
          pc_src      = 2'b01;
          pc_en       = bne_reg ? !zero_flag : zero_flag;
          state_next  = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          state_next = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          state_next = S_FETCH;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_en      = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: a full-feature and a minimal-config instance are
// checked cycle by cycle against per-instruction expected output traces built from the rules.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode      [2];
  logic [5:0] funct       [2];
  logic       zero_flag   [2];
  logic       mem_ready   [2];
  logic [2:0] alu_control [2];
  logic       alu_src_a   [2];
  logic [1:0] alu_src_b   [2];
  logic [1:0] pc_src      [2];
  logic       iord        [2];
  logic       mem_write   [2];
  logic       ir_write    [2];
  logic       reg_dest    [2];
  logic       mem_to_reg  [2];
  logic       reg_write   [2];
  logic       pc_en       [2];
  logic       illegal_op  [2];
  logic [15:0] obs_vec    [2];

  int total = 0;
  int bad   = 0;

  // Instance 0: all features on. Instance 1: no bne, no addi, handshake ignored.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mips_multicycle_ctrl #(
      .SUPPORT_BNE  (gi == 0),
      .SUPPORT_ADDI (gi == 0),
      .MEM_HANDSHAKE(gi == 0)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode[gi]),
      .funct      (funct[gi]),
      .zero_flag  (zero_flag[gi]),
      .mem_ready  (mem_ready[gi]),
      .alu_control(alu_control[gi]),
      .alu_src_a  (alu_src_a[gi]),
      .alu_src_b  (alu_src_b[gi]),
      .pc_src     (pc_src[gi]),
      .iord       (iord[gi]),
      .mem_write  (mem_write[gi]),
      .ir_write   (ir_write[gi]),
      .reg_dest   (reg_dest[gi]),
      .mem_to_reg (mem_to_reg[gi]),
      .reg_write  (reg_write[gi]),
      .pc_en      (pc_en[gi]),
      .illegal_op (illegal_op[gi])
    );
    assign obs_vec[gi] = {alu_control[gi], alu_src_a[gi], alu_src_b[gi], pc_src[gi], iord[gi],
                          mem_write[gi], ir_write[gi], reg_dest[gi], mem_to_reg[gi],
                          reg_write[gi], pc_en[gi], illegal_op[gi]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic        q_mr  [$];
  logic        q_zf  [$];
  logic [15:0] q_exp [$];
  string       q_tag [$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] alu, input logic a, input logic [1:0] b,
                                     input logic [1:0] pcs, input logic io, input logic mw,
                                     input logic irw, input logic rd, input logic m2r,
                                     input logic rw, input logic pe, input logic ill);
    return {alu, a, b, pcs, io, mw, irw, rd, m2r, rw, pe, ill};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic zf, input logic [15:0] e, input string t);
    q_mr.push_back(mr);
    q_zf.push_back(zf);
    q_exp.push_back(e);
    q_tag.push_back(t);
  endtask

  // Expected per-cycle trace of one instruction; sf/sm are stall cycles in fetch/memory, z<0 = random zero_flag.
  task automatic build(input int d, input logic [5:0] op, input logic [5:0] fn,
                       input int sf, input int sm, input int z);
    bit hs, is_lw, is_sw, is_r, is_beq, is_bne, is_addi, is_j, legal, ok, zf;
    logic [2:0] alu;
    hs      = (d == 0);
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_r    = (op == 6'b000000);
    is_beq  = (op == 6'b000100);
    is_bne  = (d == 0) && (op == 6'b000101);
    is_addi = (d == 0) && (op == 6'b001000);
    is_j    = (op == 6'b000010);
    legal   = is_lw || is_sw || is_r || is_beq || is_bne || is_addi || is_j;
    if (hs) repeat (sf) push(1'b0, rbit(), mk(3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "FETCH-stall");
    push(hs ? 1'b1 : rbit(), rbit(), mk(3'b010, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 1, 0), "FETCH");
    push(rbit(), rbit(), mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, !legal), "DECODE");
    if (is_lw || is_sw) begin
      push(rbit(), rbit(), mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "MEMADR");
      if (hs) repeat (sm) push(1'b0, rbit(), mk(3'b010, 0, 2'b00, 2'b00, 1, is_sw, 0, 0, 0, 0, 0, 0), "MEM-stall");
      push(hs ? 1'b1 : rbit(), rbit(), mk(3'b010, 0, 2'b00, 2'b00, 1, is_sw, 0, 0, 0, 0, 0, 0), is_sw ? "MEMWR" : "MEMRD");
      if (is_lw) push(rbit(), rbit(), mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0), "MEMWB");
    end else if (is_r) begin
      ok = 1'b1;
      case (fn)
        6'b100000: alu = 3'b010;
        6'b100010: alu = 3'b110;
        6'b100100: alu = 3'b000;
        6'b100101: alu = 3'b001;
        6'b101010: alu = 3'b111;
        default: begin alu = 3'b010; ok = 1'b0; end
      endcase
      push(rbit(), rbit(), mk(alu, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "EXECUTE");
      push(rbit(), rbit(), mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, ok, 0, !ok), "ALUWB");
    end else if (is_beq || is_bne) begin
      zf = (z < 0) ? rbit() : (z != 0);
      push(rbit(), zf, mk(3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, is_bne ? !zf : zf, 0), "BRANCH");
    end else if (is_addi) begin
      push(rbit(), rbit(), mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "ADDIEX");
      push(rbit(), rbit(), mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0), "ADDIWB");
    end else if (is_j) begin
      push(rbit(), rbit(), mk(3'b010, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0), "JUMP");
    end
  endtask

  // Every driving task starts and ends 1 time unit after a rising edge.
  task automatic run_queue(input int d, input int limit);
    int n = 0;
    while (q_exp.size() > 0 && n < limit) begin
      logic [15:0] e;
      string t;
      mem_ready[d] = q_mr.pop_front();
      zero_flag[d] = q_zf.pop_front();
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      @(negedge clk);
      check($sformatf("dut%0d %s", d, t), obs_vec[d], e);
      @(posedge clk); #1;
      n++;
    end
    q_mr.delete(); q_zf.delete(); q_exp.delete(); q_tag.delete();
  endtask

  task automatic do_instr(input int d, input logic [5:0] op, input logic [5:0] fn,
                          input int sf, input int sm, input int z);
    opcode[d] = op;
    funct[d]  = fn;
    build(d, op, fn, sf, sm, z);
    $display("dut%0d op=%b funct=%b stalls=%0d/%0d cycles=%0d", d, op, fn, sf, sm, q_exp.size());
    run_queue(d, 1000);
  endtask

  task automatic do_reset(input int cycles, input logic mr);
    reset = 1'b1;
    mem_ready[0] = mr;
    mem_ready[1] = mr;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("reset dut0", obs_vec[0], mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      check("reset dut1", obs_vec[1], mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic do_random(input int d, input int count);
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    for (int i = 0; i < count; i++) begin
      logic [5:0] op, fn;
      int k;
      k  = $urandom_range(0, 7);
      op = (k == 7) ? 6'($urandom_range(0, 63)) : ops[k];
      k  = $urandom_range(0, 5);
      fn = (k == 5) ? 6'($urandom_range(0, 63)) : fns[k];
      do_instr(d, op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      opcode[d] = 6'b0; funct[d] = 6'b0; zero_flag[d] = 1'b0; mem_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
    do_reset(2, 1'b1);

    do_instr(0, 6'b100011, 6'b0, 0, 0, -1);
    do_instr(0, 6'b101011, 6'b0, 0, 0, -1);
    do_instr(0, 6'b000000, 6'b100000, 0, 0, -1);
    do_instr(0, 6'b001000, 6'b0, 0, 0, -1);
    do_instr(0, 6'b000010, 6'b0, 0, 0, -1);
    do_instr(0, 6'b000100, 6'b0, 0, 0, 1);
    do_instr(0, 6'b000100, 6'b0, 0, 0, 0);
    do_instr(0, 6'b000101, 6'b0, 0, 0, 0);
    do_instr(0, 6'b000101, 6'b0, 0, 0, 1);
    do_instr(0, 6'b100011, 6'b0, 3, 3, -1);
    do_instr(0, 6'b101011, 6'b0, 2, 3, -1);
    do_instr(0, 6'b111111, 6'b0, 0, 0, -1);
    do_instr(0, 6'b000000, 6'b100010, 0, 0, -1);
    do_instr(0, 6'b000000, 6'b100100, 0, 0, -1);
    do_instr(0, 6'b000000, 6'b100101, 0, 0, -1);
    do_instr(0, 6'b000000, 6'b101010, 0, 0, -1);
    do_instr(0, 6'b000000, 6'b111111, 0, 0, -1);

    // Abandon a stalled store: reset arrives while MEMWR is waiting on memory.
    opcode[0] = 6'b101011;
    build(0, 6'b101011, 6'b0, 0, 4, -1);
    $display("dut0 sw interrupted by reset in MEMWR");
    run_queue(0, 4);
    do_reset(1, 1'b0);
    do_instr(0, 6'b000000, 6'b100000, 0, 0, -1);

    do_random(0, 150);

    do_reset(2, 1'b1);
    do_instr(1, 6'b111111, 6'b0, 0, 0, -1);
    do_instr(1, 6'b000101, 6'b0, 0, 0, 0);
    do_instr(1, 6'b001000, 6'b0, 0, 0, -1);
    do_instr(1, 6'b100011, 6'b0, 0, 0, -1);
    do_instr(1, 6'b101011, 6'b0, 0, 0, -1);
    do_instr(1, 6'b000100, 6'b0, 0, 0, 1);
    do_random(1, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
